// File: rtl/seven_seg_scan_reader.sv
// Reads a scanned active-low 7-seg bus back into hex nibbles.
// Captures stable dwells, assembles frames, flags bad codes and an glitches.
module seven_seg_scan_reader #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    frame_valid,
    output logic [NUM_DIGITS-1:0]   digit_seen,
    output logic [NUM_DIGITS-1:0]   bad_pattern,
    output logic [7:0]              glitch_cnt
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int SW = NUM_DIGITS + 7;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);

    logic [NUM_DIGITS-1:0]   r_an_m, r_an_s;
    logic [6:0]              r_seg_m, r_seg_s;
    logic [SW-1:0]           r_prev;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_slots, r_value;
    logic [NUM_DIGITS-1:0]   r_seen, r_bad;
    logic                    r_pend, r_fv;
    logic [7:0]              r_glitch;

    logic [NUM_DIGITS-1:0]   w_inv;
    logic [3:0]              w_nib;
    logic                    w_font, w_blank, w_idle, w_onehot;
    logic                    w_same, w_fire, w_cap, w_bad, w_glitch, w_done;
    logic [4*NUM_DIGITS-1:0] w_slots_nx;
    logic [NUM_DIGITS-1:0]   w_seen_nx;

    // Font inverse: segment code back to its hex nibble
    always_comb begin
        w_nib  = 4'h0;
        w_font = 1'b1;
        case (r_seg_s)
            7'h01: w_nib = 4'h0;
            7'h4F: w_nib = 4'h1;
            7'h12: w_nib = 4'h2;
            7'h06: w_nib = 4'h3;
            7'h4C: w_nib = 4'h4;
            7'h24: w_nib = 4'h5;
            7'h20: w_nib = 4'h6;
            7'h0F: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h0C: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h60: w_nib = 4'hB;
            7'h31: w_nib = 4'hC;
            7'h42: w_nib = 4'hD;
            7'h30: w_nib = 4'hE;
            7'h38: w_nib = 4'hF;
            default: w_font = 1'b0;
        endcase
    end

    assign w_blank  = (r_seg_s == 7'h7F);
    assign w_inv    = ~r_an_s;
    assign w_idle   = (w_inv == '0);
    assign w_onehot = !w_idle
                   && ((w_inv & (w_inv - NUM_DIGITS'(1))) == '0);
    assign w_same   = ({r_an_s, r_seg_s} == r_prev);
    assign w_fire   = w_same && (r_cnt == CNT_FIRE);
    assign w_cap    = w_fire && w_onehot && w_font;
    assign w_bad    = w_fire && w_onehot && !w_font && !w_blank;
    assign w_glitch = w_fire && !w_idle && !w_onehot;

    // Slot/seen image including the capture happening this cycle
    always_comb begin
        w_slots_nx = r_slots;
        w_seen_nx  = r_seen;
        if (w_cap) begin
            w_seen_nx = r_seen | w_inv;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_inv[i]) w_slots_nx[4*i +: 4] = w_nib;
            end
        end
    end

    assign w_done = w_cap && (w_seen_nx == '1);

    // Two-flop synchronisers for the asynchronous display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_m  <= '0;
            r_an_s  <= '0;
            r_seg_m <= '0;
            r_seg_s <= '0;
        end else begin
            r_an_m  <= an;
            r_an_s  <= r_an_m;
            r_seg_m <= seg;
            r_seg_s <= r_seg_m;
        end
    end

    // Dwell counter: restarts on any change, saturates at the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= {r_an_s, r_seg_s};
            if (!w_same)              r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame assembly; completion publishes now, pulses and clears next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots <= '0;
            r_value <= '0;
            r_seen  <= '0;
            r_pend  <= 1'b0;
            r_fv    <= 1'b0;
        end else begin
            r_slots <= w_slots_nx;
            r_fv    <= r_pend;
            r_pend  <= w_done;
            if (w_done) r_value <= w_slots_nx;
            r_seen  <= r_pend ? '0 : w_seen_nx;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad    <= '0;
            r_glitch <= '0;
        end else begin
            if (w_bad) r_bad <= r_bad | w_inv;
            if (w_glitch && r_glitch != 8'hFF) r_glitch <= r_glitch + 8'd1;
        end
    end

    assign value       = r_value;
    assign frame_valid = r_fv;
    assign digit_seen  = r_seen;
    assign bad_pattern = r_bad;
    assign glitch_cnt  = r_glitch;

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Directed bench for seven_seg_scan_reader.
// Expected frames queue up at stimulus time and are popped on frame_valid.
module tb_seven_seg_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] value8;
    logic        fv8;
    logic [7:0]  seen8, bad8, glitch8;

    logic [0:0]  an1;
    logic [6:0]  seg1;
    logic [3:0]  value1;
    logic        fv1;
    logic [0:0]  seen1, bad1;
    logic [7:0]  glitch1;

    int checks = 0;
    int failures = 0;
    int fcnt8 = 0;
    int fcnt1 = 0;
    logic [31:0] q8[$];
    logic [31:0] q1[$];

    logic [6:0] font [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                             7'h20, 7'h0F, 7'h00, 7'h0C, 7'h08, 7'h60,
                             7'h31, 7'h42, 7'h30, 7'h38};

    always #5 clk = ~clk;

    seven_seg_scan_reader #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .value(value8), .frame_valid(fv8), .digit_seen(seen8),
        .bad_pattern(bad8), .glitch_cnt(glitch8)
    );

    seven_seg_scan_reader #(.NUM_DIGITS(1), .STABLE_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .an(an1), .seg(seg1),
        .value(value1), .frame_valid(fv1), .digit_seen(seen1),
        .bad_pattern(bad1), .glitch_cnt(glitch1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s,
                        input int n);
        an = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dig(input int i, input int nib, input int n);
        logic [7:0] m;
        m = 8'h01 << i;
        hold(~m, font[nib], n);
    endtask

    task automatic hold1(input logic a, input logic [6:0] s, input int n);
        an1 = a;
        seg1 = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (fv8) begin
            fcnt8++;
            chk("q8_has_expect", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) chk("frame8", value8, q8.pop_front());
        end
        if (fv1) begin
            fcnt1++;
            chk("q1_has_expect", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) chk("frame1", 32'(value1), q1.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        an = 8'hFF;
        seg = 7'h7F;
        an1 = 1'b1;
        seg1 = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value8, 32'h0);
        chk("rst_fv", 32'(fv8), 32'h0);
        chk("rst_seen", 32'(seen8), 32'h0);
        chk("rst_bad", 32'(bad8), 32'h0);
        chk("rst_glitch", 32'(glitch8), 32'h0);
        rst_n = 1'b1;
        hold(8'hFF, 7'h7F, 6);

        // full scan 1..8
        q8.push_back(32'h8765_4321);
        for (int i = 0; i < 8; i++) dig(i, i + 1, 6);
        hold(8'hFF, 7'h7F, 10);
        chk("t1_frames", 32'(fcnt8), 32'd1);
        chk("t1_seen_clr", 32'(seen8), 32'h0);

        // every font code on a single-digit reader
        for (int n = 0; n < 16; n++) begin
            q1.push_back(32'(n));
            hold1(1'b0, font[n], 6);
        end
        hold1(1'b0, 7'h7F, 6);
        hold1(1'b0, 7'h7E, 6);
        hold1(1'b1, 7'h7F, 10);
        chk("t2_frames", 32'(fcnt1), 32'd16);
        chk("t2_value", 32'(value1), 32'hF);
        chk("t2_bad", 32'(bad1), 32'h1);

        // dwell length boundary
        dig(3, 5, 3);
        hold(8'hFF, 7'h7F, 8);
        chk("t3_short", 32'(seen8), 32'h0);
        dig(3, 5, 4);
        hold(8'hFF, 7'h7F, 8);
        chk("t3_exact", 32'(seen8), 32'h08);

        // glitch counting and saturation
        for (int k = 0; k < 3; k++) begin
            hold(8'hFC, 7'h01, 10);
            hold(8'hFF, 7'h7F, 6);
        end
        chk("t4_glitch3", 32'(glitch8), 32'd3);
        for (int k = 0; k < 297; k++) begin
            hold((k % 2 == 0) ? 8'hFC : 8'hF3, 7'h01, 5);
        end
        hold(8'hFF, 7'h7F, 8);
        chk("t4_glitch_sat", 32'(glitch8), 32'd255);
        chk("t4_no_bad", 32'(bad8), 32'h0);

        // reset discards a partial frame
        for (int i = 0; i < 7; i++) dig(i, 2, 6);
        hold(8'hFF, 7'h7F, 6);
        chk("t5_seen7", 32'(seen8), 32'h7F);
        chk("t5_value_old", value8, 32'h8765_4321);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_value_rst", value8, 32'h0);
        chk("t5_seen_rst", 32'(seen8), 32'h0);
        chk("t5_glitch_rst", 32'(glitch8), 32'h0);
        hold(8'hFF, 7'h7F, 6);
        q8.push_back(32'h0FED_CBA9);
        for (int i = 0; i < 7; i++) dig(i, 9 + i, 6);
        hold(8'hFF, 7'h7F, 6);
        chk("t5_value_hold", value8, 32'h0);
        chk("t5_frames_mid", 32'(fcnt8), 32'd1);
        dig(7, 0, 6);
        hold(8'hFF, 7'h7F, 10);
        chk("t5_frames", 32'(fcnt8), 32'd2);

        // overwrite of an already-seen digit
        q8.push_back(32'h7654_3A10);
        dig(0, 0, 6);
        dig(1, 1, 6);
        dig(2, 5, 6);
        dig(3, 3, 6);
        dig(2, 10, 6);
        hold(8'hFF, 7'h7F, 8);
        chk("t6_seen", 32'(seen8), 32'h0F);
        chk("t6_no_frame", 32'(fcnt8), 32'd2);
        for (int i = 4; i < 8; i++) dig(i, i, 6);
        hold(8'hFF, 7'h7F, 10);
        chk("t6_frames", 32'(fcnt8), 32'd3);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
